// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR input sequencer: FSM states, widths and
// the packing of a 16-bit tap set into the three coefficient-shift words.
package fir_pkg;

  localparam int FIR_W      = 6;
  localparam int FIR_TAPS   = 8;
  localparam int CFG_CYCLES = 3;
  localparam int CFG_WORD_W = 2 * FIR_TAPS;

  typedef enum logic [1:0] {
    IDLE,
    CFG,
    GAP,
    STREAM
  } fir_state_e;

  function automatic logic [1:0] cfg_tap(input logic [CFG_WORD_W-1:0] word, input int idx);
    return word[2*idx +: 2];
  endfunction

  // The FIR shifts coefficients in highest taps first, three 2-bit taps per word.
  function automatic logic [FIR_W-1:0] cfg_slice(input logic [CFG_WORD_W-1:0] word,
                                                 input logic [1:0] step);
    logic [FIR_W-1:0] slice;
    case (step)
      2'd0:    slice = {cfg_tap(word, 6), cfg_tap(word, 7), 2'b00};
      2'd1:    slice = {cfg_tap(word, 3), cfg_tap(word, 4), cfg_tap(word, 5)};
      default: slice = {cfg_tap(word, 0), cfg_tap(word, 1), cfg_tap(word, 2)};
    endcase
    return slice;
  endfunction

endpackage

// File: rtl/fir_input_sequencer_if.sv
// Sample-in handshake plus FIR-facing outputs of the sequencer.
// slave = the sequencer itself, master = the upstream source / FIR side.
interface fir_seq_if #(
  parameter int W = fir_pkg::FIR_W
);
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x_n;
  logic         s_axis_fir_tvalid;
  logic         s_set_coeffs;

  modport master (
    output in_data, in_valid,
    input  in_ready, x_n, s_axis_fir_tvalid, s_set_coeffs
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, x_n, s_axis_fir_tvalid, s_set_coeffs
  );
endinterface

// File: rtl/fir_sample_fifo.sv
// Small synchronous sample FIFO with an occupancy counter; full/empty derive from it.
// Read data is the current head (show-ahead), valid whenever empty is low.
module fir_sample_fifo
  import fir_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = FIR_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and infers a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: flops use non-blocking (<=) so every register samples pre-edge values regardless of statement order.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; an entry is only read after it was written, and this keeps it RAM-mappable.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/fir_input_sequencer.sv
// Upstream feeder for the 8-tap FIR: sample FIFO, coefficient-load sequence, gap-free streaming.
// Build option: define FIR_SEQ_HOLD_EN to repeat the last streamed sample on underflow (else 0).
module fir_input_sequencer
  import fir_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = FIR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  fir_seq_if.slave              bus,
  input  logic                  stream_en,
  input  logic                  cfg_req,
  input  logic [CFG_WORD_W-1:0] cfg_word,
  output logic                  busy,
  output logic [7:0]            underrun_cnt
);

  fir_state_e            state_q, state_d;
  logic [1:0]            cfg_cnt_q, cfg_cnt_d;
  logic                  pend_q, pend_d;
  logic [CFG_WORD_W-1:0] cfg_word_q, cfg_word_d;
  logic [CFG_WORD_W-1:0] load_word_q, load_word_d;
  logic [W-1:0]          x_n_q, x_n_d;
  logic                  tvalid_q, tvalid_d;
  logic                  set_coeffs_q, set_coeffs_d;
  logic [7:0]            underrun_q, underrun_d;

  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [W-1:0]          fifo_head;
  logic [W-1:0]          underflow_val;
  logic                  underflow;
  logic                  cfg_pending;

  assign bus.in_ready = ~fifo_full;
  assign fifo_push    = bus.in_valid & ~fifo_full;

  fir_sample_fifo #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (bus.in_data),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef FIR_SEQ_HOLD_EN
  logic [W-1:0] last_q, last_d;

  always_comb begin
    last_d = last_q;
    if (fifo_pop) last_d = fifo_head;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_q <= '0;
    else       last_q <= last_d;
  end

  assign underflow_val = last_q;
`else
  assign underflow_val = '0;
`endif

  // Leaving STREAM on the request edge itself lets CFG begin one edge later, as from IDLE.
  assign cfg_pending = pend_q | cfg_req;

  always_comb begin
    state_d      = state_q;
    cfg_cnt_d    = cfg_cnt_q;
    pend_d       = pend_q;
    cfg_word_d   = cfg_word_q;
    load_word_d  = load_word_q;
    x_n_d        = '0;
    tvalid_d     = 1'b0;
    set_coeffs_d = 1'b0;
    fifo_pop     = 1'b0;
    underflow    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pend_q) begin
          state_d      = CFG;
          cfg_cnt_d    = '0;
          pend_d       = 1'b0;
          load_word_d  = cfg_word_q;
          set_coeffs_d = 1'b1;
          x_n_d        = W'(cfg_slice(cfg_word_q, 2'd0));
        end else if (!cfg_pending && stream_en && !fifo_empty) begin
          state_d  = STREAM;
          tvalid_d = 1'b1;
          fifo_pop = 1'b1;
          x_n_d    = fifo_head;
        end
      end
      CFG: begin
        // The in-progress load reads its own copy, so a new request cannot disturb it.
        if (cfg_cnt_q == 2'(CFG_CYCLES - 1)) begin
          state_d = GAP;
        end else begin
          cfg_cnt_d    = cfg_cnt_q + 2'd1;
          set_coeffs_d = 1'b1;
          x_n_d        = W'(cfg_slice(load_word_q, cfg_cnt_q + 2'd1));
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      STREAM: begin
        if (!stream_en || cfg_pending) begin
          state_d = IDLE;
        end else begin
          tvalid_d = 1'b1;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            x_n_d    = fifo_head;
          end else begin
            underflow = 1'b1;
            x_n_d     = underflow_val;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (cfg_req) begin
      pend_d     = 1'b1;
      cfg_word_d = cfg_word;
    end

    underrun_d = underrun_q;
    if (underflow && underrun_q != 8'hFF) underrun_d = underrun_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cfg_cnt_q    <= '0;
      pend_q       <= 1'b0;
      cfg_word_q   <= '0;
      load_word_q  <= '0;
      x_n_q        <= '0;
      tvalid_q     <= 1'b0;
      set_coeffs_q <= 1'b0;
      underrun_q   <= '0;
    end else begin
      state_q      <= state_d;
      cfg_cnt_q    <= cfg_cnt_d;
      pend_q       <= pend_d;
      cfg_word_q   <= cfg_word_d;
      load_word_q  <= load_word_d;
      x_n_q        <= x_n_d;
      tvalid_q     <= tvalid_d;
      set_coeffs_q <= set_coeffs_d;
      underrun_q   <= underrun_d;
    end
  end

  assign bus.x_n               = x_n_q;
  assign bus.s_axis_fir_tvalid = tvalid_q;
  assign bus.s_set_coeffs      = set_coeffs_q;
  assign busy                  = (state_q != IDLE);
  assign underrun_cnt          = underrun_q;

endmodule

// File: tb/tb_fir_input_sequencer.sv
// Directed self-checking bench for fir_input_sequencer (DEPTH=4, W=6).
// Each step drives inputs, waits one rising edge + 1, then compares all observable outputs.
module tb_fir_input_sequencer;

  localparam int DEPTH = 4;
  localparam int W     = 6;

`ifdef FIR_SEQ_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  // Tap sets used below, with their three shift words worked out by hand.
  // 16'h1155: t7..t0 = 00,01,00,01,01,01,01,01
  localparam logic [15:0] WORD_A = 16'h1155;
  localparam logic [5:0]  A0 = 6'b010000;  // {t6,t7,00}
  localparam logic [5:0]  A1 = 6'b010100;  // {t3,t4,t5}
  localparam logic [5:0]  A2 = 6'b010101;  // {t0,t1,t2}
  // 16'hE41B: t7..t0 = 11,10,01,00,00,01,10,11
  localparam logic [15:0] WORD_B = 16'hE41B;
  localparam logic [5:0]  B0 = 6'b101100;
  localparam logic [5:0]  B1 = 6'b000001;
  localparam logic [5:0]  B2 = 6'b111001;

  logic       clk = 1'b0;
  logic       reset;
  logic       stream_en;
  logic       cfg_req;
  logic [15:0] cfg_word;
  logic       busy;
  logic [7:0] underrun_cnt;

  int compared   = 0;
  int mismatched = 0;

  typedef struct packed {
    logic        v;
    logic [5:0]  d;
    logic        s;
    logic        cr;
    logic [15:0] cw;
    logic [17:0] want;
  } step_t;

  fir_seq_if #(.W(W)) bus ();

  fir_input_sequencer #(
    .DEPTH (DEPTH),
    .W     (W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus.slave),
    .stream_en    (stream_en),
    .cfg_req      (cfg_req),
    .cfg_word     (cfg_word),
    .busy         (busy),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected-output vector: {set_coeffs, tvalid, busy, in_ready, x_n, underrun_cnt}
  function automatic logic [17:0] ev(input logic set, input logic valid, input logic bsy,
                                     input logic rdy, input logic [5:0] x, input logic [7:0] ur);
    return {set, valid, bsy, rdy, x, ur};
  endfunction

  function automatic step_t st(input logic v, input logic [5:0] d, input logic s,
                               input logic cr, input logic [15:0] cw, input logic [17:0] want);
    step_t r;
    r.v = v; r.d = d; r.s = s; r.cr = cr; r.cw = cw; r.want = want;
    return r;
  endfunction

  function automatic logic [17:0] status();
    return {bus.s_set_coeffs, bus.s_axis_fir_tvalid, busy, bus.in_ready, bus.x_n, underrun_cnt};
  endfunction

  function automatic string fmt(input logic [17:0] v);
    return $sformatf("set=%b valid=%b busy=%b rdy=%b x_n=%b ur=%0d",
                     v[17], v[16], v[15], v[14], v[13:8], v[7:0]);
  endfunction

  task automatic apply(input step_t s);
    bus.in_valid = s.v;
    bus.in_data  = s.d;
    stream_en    = s.s;
    cfg_req      = s.cr;
    cfg_word     = s.cw;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [17:0] got;
    got = status();
    compared++;
    if (got !== ev(0, 0, 0, 1, 6'd0, 8'd0)) begin
      mismatched++;
      $display("FAIL reset_state: got %s, want %s", fmt(got), fmt(ev(0, 0, 0, 1, 6'd0, 8'd0)));
    end
  endtask

  task automatic test_cfg();
    step_t q[$];
    logic [17:0] got;
    q.push_back(st(0, 0, 0, 1, WORD_A, ev(0, 0, 0, 1, 6'd0, 8'd0)));  // request latched, still IDLE
    q.push_back(st(0, 0, 0, 0, 16'h0,  ev(1, 0, 1, 1, A0, 8'd0)));
    q.push_back(st(0, 0, 0, 1, WORD_B, ev(1, 0, 1, 1, A1, 8'd0)));    // re-request mid-CFG
    q.push_back(st(0, 0, 0, 0, 16'h0,  ev(1, 0, 1, 1, A2, 8'd0)));
    q.push_back(st(0, 0, 0, 0, 16'h0,  ev(0, 0, 1, 1, 6'd0, 8'd0)));  // GAP
    q.push_back(st(0, 0, 0, 0, 16'h0,  ev(0, 0, 0, 1, 6'd0, 8'd0)));  // IDLE
    q.push_back(st(0, 0, 0, 0, 16'h0,  ev(1, 0, 1, 1, B0, 8'd0)));    // queued load
    q.push_back(st(0, 0, 0, 0, 16'h0,  ev(1, 0, 1, 1, B1, 8'd0)));
    q.push_back(st(0, 0, 0, 0, 16'h0,  ev(1, 0, 1, 1, B2, 8'd0)));
    q.push_back(st(0, 0, 0, 0, 16'h0,  ev(0, 0, 1, 1, 6'd0, 8'd0)));
    q.push_back(st(0, 0, 0, 0, 16'h0,  ev(0, 0, 0, 1, 6'd0, 8'd0)));
    foreach (q[i]) begin
      apply(q[i]);
      got = status();
      compared++;
      if (got !== q[i].want) begin
        mismatched++;
        $display("FAIL cfg step %0d: got %s, want %s", i, fmt(got), fmt(q[i].want));
      end
    end
  endtask

  task automatic test_stream();
    step_t q[$];
    logic [17:0] got;
    logic [5:0] u7, u9;
    u7 = HOLD ? 6'd7 : 6'd0;
    u9 = HOLD ? 6'd9 : 6'd0;
    q.push_back(st(1, 6'd3,      0, 0, 0, ev(0, 0, 0, 1, 6'd0, 8'd0)));
    q.push_back(st(1, 6'b111110, 0, 0, 0, ev(0, 0, 0, 1, 6'd0, 8'd0)));
    q.push_back(st(1, 6'd7,      0, 0, 0, ev(0, 0, 0, 1, 6'd0, 8'd0)));
    q.push_back(st(0, 6'd0, 1, 0, 0, ev(0, 1, 1, 1, 6'd3, 8'd0)));
    q.push_back(st(0, 6'd0, 1, 0, 0, ev(0, 1, 1, 1, 6'b111110, 8'd0)));
    q.push_back(st(0, 6'd0, 1, 0, 0, ev(0, 1, 1, 1, 6'd7, 8'd0)));
    q.push_back(st(0, 6'd0, 1, 0, 0, ev(0, 1, 1, 1, u7, 8'd1)));   // first underflow
    q.push_back(st(1, 6'd9, 1, 0, 0, ev(0, 1, 1, 1, u7, 8'd2)));   // push into empty: still underflow
    q.push_back(st(0, 6'd0, 1, 0, 0, ev(0, 1, 1, 1, 6'd9, 8'd2)));  // one-edge latency
    q.push_back(st(0, 6'd0, 1, 0, 0, ev(0, 1, 1, 1, u9, 8'd3)));
    q.push_back(st(0, 6'd0, 0, 0, 0, ev(0, 0, 0, 1, 6'd0, 8'd3)));
    foreach (q[i]) begin
      apply(q[i]);
      got = status();
      compared++;
      if (got !== q[i].want) begin
        mismatched++;
        $display("FAIL stream step %0d: got %s, want %s", i, fmt(got), fmt(q[i].want));
      end
    end
  endtask

  task automatic test_fifo_full();
    step_t q[$];
    logic [17:0] got;
    q.push_back(st(1, 6'd1, 0, 0, 0, ev(0, 0, 0, 1, 6'd0, 8'd3)));
    q.push_back(st(1, 6'd2, 0, 0, 0, ev(0, 0, 0, 1, 6'd0, 8'd3)));
    q.push_back(st(1, 6'd3, 0, 0, 0, ev(0, 0, 0, 1, 6'd0, 8'd3)));
    q.push_back(st(1, 6'd4, 0, 0, 0, ev(0, 0, 0, 0, 6'd0, 8'd3)));  // full
    q.push_back(st(1, 6'd5, 0, 0, 0, ev(0, 0, 0, 0, 6'd0, 8'd3)));  // 5th held off
    q.push_back(st(1, 6'd5, 1, 0, 0, ev(0, 1, 1, 1, 6'd1, 8'd3)));  // pop while full, no push
    q.push_back(st(1, 6'd5, 1, 0, 0, ev(0, 1, 1, 1, 6'd2, 8'd3)));  // 5th accepted
    q.push_back(st(0, 6'd0, 1, 0, 0, ev(0, 1, 1, 1, 6'd3, 8'd3)));
    q.push_back(st(0, 6'd0, 1, 0, 0, ev(0, 1, 1, 1, 6'd4, 8'd3)));
    q.push_back(st(0, 6'd0, 1, 0, 0, ev(0, 1, 1, 1, 6'd5, 8'd3)));
    q.push_back(st(0, 6'd0, 1, 0, 0, ev(0, 1, 1, 1, HOLD ? 6'd5 : 6'd0, 8'd4)));
    q.push_back(st(0, 6'd0, 0, 0, 0, ev(0, 0, 0, 1, 6'd0, 8'd4)));
    foreach (q[i]) begin
      apply(q[i]);
      got = status();
      compared++;
      if (got !== q[i].want) begin
        mismatched++;
        $display("FAIL fifo_full step %0d: got %s, want %s", i, fmt(got), fmt(q[i].want));
      end
    end
  endtask

  task automatic test_cfg_during_stream();
    step_t q[$];
    logic [17:0] got;
    q.push_back(st(1, 6'd10, 0, 0, 0, ev(0, 0, 0, 1, 6'd0, 8'd4)));
    q.push_back(st(1, 6'd11, 0, 0, 0, ev(0, 0, 0, 1, 6'd0, 8'd4)));
    q.push_back(st(1, 6'd12, 0, 0, 0, ev(0, 0, 0, 1, 6'd0, 8'd4)));
    q.push_back(st(0, 6'd0, 1, 0, 0,      ev(0, 1, 1, 1, 6'd10, 8'd4)));
    q.push_back(st(0, 6'd0, 1, 1, WORD_A, ev(0, 0, 0, 1, 6'd0, 8'd4)));  // STREAM -> IDLE
    q.push_back(st(0, 6'd0, 1, 0, 0,      ev(1, 0, 1, 1, A0, 8'd4)));
    q.push_back(st(0, 6'd0, 1, 0, 0,      ev(1, 0, 1, 1, A1, 8'd4)));
    q.push_back(st(0, 6'd0, 1, 0, 0,      ev(1, 0, 1, 1, A2, 8'd4)));
    q.push_back(st(0, 6'd0, 1, 0, 0,      ev(0, 0, 1, 1, 6'd0, 8'd4)));  // GAP
    q.push_back(st(0, 6'd0, 1, 0, 0,      ev(0, 0, 0, 1, 6'd0, 8'd4)));  // IDLE
    q.push_back(st(0, 6'd0, 1, 0, 0,      ev(0, 1, 1, 1, 6'd11, 8'd4)));
    q.push_back(st(0, 6'd0, 1, 0, 0,      ev(0, 1, 1, 1, 6'd12, 8'd4)));
    q.push_back(st(0, 6'd0, 1, 0, 0,      ev(0, 1, 1, 1, HOLD ? 6'd12 : 6'd0, 8'd5)));
    q.push_back(st(0, 6'd0, 0, 0, 0,      ev(0, 0, 0, 1, 6'd0, 8'd5)));
    foreach (q[i]) begin
      apply(q[i]);
      got = status();
      compared++;
      if (got !== q[i].want) begin
        mismatched++;
        $display("FAIL cfg_in_stream step %0d: got %s, want %s", i, fmt(got), fmt(q[i].want));
      end
    end
  endtask

  task automatic test_underrun_sat();
    logic [17:0] got, want;
    logic [5:0]  u;
    int          exp_ur;
    u = HOLD ? 6'd20 : 6'd0;
    apply(st(1, 6'd20, 1, 0, 0, 18'd0));  // FIFO was empty at this edge: stays IDLE
    apply(st(0, 6'd0,  1, 0, 0, 18'd0));
    got = status();
    compared++;
    if (got !== ev(0, 1, 1, 1, 6'd20, 8'd5)) begin
      mismatched++;
      $display("FAIL sat_entry: got %s, want %s", fmt(got), fmt(ev(0, 1, 1, 1, 6'd20, 8'd5)));
    end
    for (int k = 1; k <= 300; k++) begin
      apply(st(0, 6'd0, 1, 0, 0, 18'd0));
      exp_ur = (5 + k > 255) ? 255 : 5 + k;
      want = ev(0, 1, 1, 1, u, 8'(exp_ur));
      got = status();
      compared++;
      if (got !== want) begin
        mismatched++;
        $display("FAIL sat cycle %0d: got %s, want %s", k, fmt(got), fmt(want));
      end
    end
    apply(st(0, 6'd0, 0, 0, 0, 18'd0));
  endtask

  task automatic test_reset_mid_cfg();
    logic [17:0] got;
    apply(st(0, 6'd0, 0, 1, WORD_B, 18'd0));
    apply(st(0, 6'd0, 0, 0, 0, 18'd0));
    got = status();
    compared++;
    if (got !== ev(1, 0, 1, 1, B0, 8'd255)) begin
      mismatched++;
      $display("FAIL rst_cfg_pre: got %s, want %s", fmt(got), fmt(ev(1, 0, 1, 1, B0, 8'd255)));
    end
    #2 reset = 1'b1;
    #1;
    got = status();
    compared++;
    if (got !== ev(0, 0, 0, 1, 6'd0, 8'd0)) begin
      mismatched++;
      $display("FAIL rst_cfg_async: got %s, want %s", fmt(got), fmt(ev(0, 0, 0, 1, 6'd0, 8'd0)));
    end
    #3 reset = 1'b0;
    apply(st(0, 6'd0, 0, 0, 0, 18'd0));
    apply(st(0, 6'd0, 0, 0, 0, 18'd0));
    got = status();
    compared++;
    if (got !== ev(0, 0, 0, 1, 6'd0, 8'd0)) begin
      mismatched++;
      $display("FAIL rst_cfg_after: got %s, want %s", fmt(got), fmt(ev(0, 0, 0, 1, 6'd0, 8'd0)));
    end
  endtask

  initial begin
    reset        = 1'b1;
    stream_en    = 1'b0;
    cfg_req      = 1'b0;
    cfg_word     = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    #12 reset = 1'b0;
    #1;
    test_reset();
    test_cfg();
    test_stream();
    test_fifo_full();
    test_cfg_during_stream();
    test_underrun_sat();
    test_reset_mid_cfg();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
